bus_sram_responder: RTL

Single-port word-wide memory that sits on the slave end of the shared `bus_if` data bus and answers requests issued by the execute unit. Reads are held until the responder returns data with a one-cycle `ready` pulse. Writes are posted: they commit with byte strobes on the acceptance edge and produce no `ready`. The block backs data memory in the TTA core and in testbenches.

---
 rtl/bus_sram_responder_pkg.sv | 14 +
 rtl/bus_sram_responder_if.sv | 16 +
 rtl/bus_sram_responder_sram_array.sv | 38 +++
 rtl/bus_sram_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/bus_sram_responder_pkg.sv
// Shared bus types: responder state encoding and the error return word.
// Imported by the bus responder and its testbench.
package bus_pkg;

    typedef enum logic [1:0] {
        BUS_RESP_IDLE,
        BUS_RESP_WAIT,
        BUS_RESP_RESP
    } BusRespState;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          BUS_WAIT_W   = 4;

endpackage

// File: rtl/bus_sram_responder_if.sv
// Shared data bus between the execute unit (master) and memory-like slaves.
// Reads complete on a one-cycle ready pulse; writes are posted with no ready.
interface bus_if;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] write_data;
    logic        instr;
    logic        ready;
    logic [31:0] read_data;

    modport master (output valid, addr, wstrb, write_data, instr,
                    input  ready, read_data);
    modport slave  (input  valid, addr, wstrb, write_data, instr,
                    output ready, read_data);
endinterface

// File: rtl/bus_sram_responder_sram_array.sv
// Single-port word memory with per-byte write enables and a registered read port.
// Latency: write commits on the edge, read data appears after the enable edge; no backpressure.
module sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WIDTH       = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic                           rd_en_i,
    input  logic [WIDTH/8-1:0]             be_i,
    input  logic [WIDTH-1:0]               wdata_i,
    output logic [WIDTH-1:0]               rdata_o
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately left out of reset so data survives a core reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_sram_responder.sv
// Bus slave SRAM: posted byte-strobed writes, reads answered by a one-cycle ready pulse.
// Latency: read 1+WAIT_STATES cycles, write 0; one request in flight (IDLE-only accept).
// Optional BUS_SRAM_BOUNDS_CHECK_EN: drop/flag out-of-range accesses, sticky err_o.
module bus_sram_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    bus_if.slave  bus,
    output logic  err_o
);
    localparam int                    AW        = $clog2(DEPTH_WORDS);
    localparam logic [BUS_WAIT_W-1:0] WAIT_INIT = BUS_WAIT_W'(WAIT_STATES);

    BusRespState           state_q;
    logic [BUS_WAIT_W-1:0] cnt_q;
    logic                  ready_q;

    logic        accept;
    logic        is_wr;
    logic        is_rd;
    logic        oor;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        unused_bits;

    assign accept = (state_q == BUS_RESP_IDLE) && bus.valid;
    assign is_wr  = accept && (bus.wstrb != 4'b0000);
    assign is_rd  = accept && (bus.wstrb == 4'b0000);
    assign mem_be = (is_wr && !oor) ? bus.wstrb : 4'b0000;

    // Low byte-lane bits and instr carry no meaning for a data memory.
    assign unused_bits = ^{bus.instr, bus.addr};

    sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WIDTH       (32)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (bus.addr[AW+1:2]),
        .rd_en_i (is_rd),
        .be_i    (mem_be),
        .wdata_i (bus.write_data),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= BUS_RESP_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                BUS_RESP_IDLE: begin
                    ready_q <= 1'b0;
                    if (is_rd) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= BUS_RESP_RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= BUS_RESP_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                BUS_RESP_WAIT: begin
                    if (cnt_q == BUS_WAIT_W'(1)) begin
                        state_q <= BUS_RESP_RESP;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - BUS_WAIT_W'(1);
                    end
                end
                // Master still shows the old valid here, so never accept on this edge.
                BUS_RESP_RESP: begin
                    state_q <= BUS_RESP_IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= BUS_RESP_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;

`ifdef BUS_SRAM_BOUNDS_CHECK_EN
    logic err_q;
    logic rd_oor_q;

    assign oor = (bus.addr >> (AW + 2)) != 32'd0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q    <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            if (accept && oor) begin
                err_q <= 1'b1;
            end
            if (is_rd) begin
                rd_oor_q <= oor;
            end
        end
    end

    assign err_o         = err_q;
    assign bus.read_data = rd_oor_q ? BUS_ERR_DATA : mem_rdata;
`else
    assign oor           = 1'b0;
    assign err_o         = 1'b0;
    assign bus.read_data = mem_rdata;
`endif

endmodule
